// File: rtl/demux.sv
// Receive end of a 4-slot time-multiplexed link: collects LARGURA-bit slots
// sampled on en pulses and presents each complete frame as one parallel word.
module demux #(
  parameter int LARGURA = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   sync,
  input  logic [LARGURA-1:0]     entrada,
  output logic [4*LARGURA-1:0]   saida,
  output logic                   valido,
  output logic                   erro,
  output logic [1:0]             slot
);

  typedef enum logic {
    OCIOSO,
    RECEBE
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [1:0]         slot_next;
  logic [LARGURA-1:0] slot_buf [0:2];

  logic store0;
  logic store1;
  logic store2;
  logic frame_done;
  logic frame_err;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= OCIOSO;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    if (en) begin
      unique case (state)
        OCIOSO: if (sync)                state_next = RECEBE;
        RECEBE: if (!sync && slot == 2'd3) state_next = OCIOSO;
        default:                          state_next = OCIOSO;
      endcase
    end
  end

  // Datapath decode: a sync pulse always restarts the frame at slot 0, so
  // the premature-sync case reuses the same slot-0 store as a normal start.
  always_comb begin
    store0     = 1'b0;
    store1     = 1'b0;
    store2     = 1'b0;
    frame_done = 1'b0;
    frame_err  = 1'b0;
    slot_next  = slot;
    if (en) begin
      if (sync) begin
        store0    = 1'b1;
        slot_next = 2'd1;
        frame_err = (state == RECEBE);
      end else if (state == RECEBE) begin
        unique case (slot)
          2'd1: begin store1 = 1'b1; slot_next = 2'd2; end
          2'd2: begin store2 = 1'b1; slot_next = 2'd3; end
          2'd3: begin frame_done = 1'b1; slot_next = 2'd0; end
          default: slot_next = 2'd0;
        endcase
      end
    end
  end

  // Slot counter, slot buffer and registered outputs.
  // NOTE: the slot buffer is small and its contents are observable through
  // the reset-to-zero requirement, so it is reset like any other register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot        <= 2'd0;
      slot_buf[0] <= '0;
      slot_buf[1] <= '0;
      slot_buf[2] <= '0;
      saida       <= '0;
      valido      <= 1'b0;
      erro        <= 1'b0;
    end else begin
      slot   <= slot_next;
      valido <= frame_done;
      erro   <= frame_err;
      if (store0) slot_buf[0] <= entrada;
      if (store1) slot_buf[1] <= entrada;
      if (store2) slot_buf[2] <= entrada;
      // Slot 3 goes straight to the output so the frame appears one edge later.
      if (frame_done) saida <= {entrada, slot_buf[2], slot_buf[1], slot_buf[0]};
    end
  end

endmodule

// File: tb/tb_demux.sv
// Directed bench for demux: frames, gaps, discarded slots, resync,
// asynchronous reset mid-frame and back-to-back frames.
module tb_demux;

  localparam int LARGURA = 4;

  logic                 clk;
  logic                 reset;
  logic                 en;
  logic                 sync;
  logic [LARGURA-1:0]   entrada;
  logic [4*LARGURA-1:0] saida;
  logic                 valido;
  logic                 erro;
  logic [1:0]           slot;

  int errors;
  int checks;
  int valido_cnt;
  int erro_cnt;
  int both_cnt;

  demux #(.LARGURA(LARGURA)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .sync    (sync),
    .entrada (entrada),
    .saida   (saida),
    .valido  (valido),
    .erro    (erro),
    .slot    (slot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts high cycles of each pulse output, sampled just after each edge.
  always @(posedge clk) begin
    #1;
    if (valido) valido_cnt++;
    if (erro) erro_cnt++;
    if (valido && erro) both_cnt++;
  end

  // One en pulse spanning exactly one rising edge; returns at the next falling edge.
  task automatic send(input logic s, input logic [LARGURA-1:0] d);
    @(negedge clk);
    en = 1'b1; sync = s; entrada = d;
    @(negedge clk);
    en = 1'b0; sync = 1'b0; entrada = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; en = 1'b0; sync = 1'b0; entrada = '0;
    #1;
    checks++;
    if (saida !== 16'h0000) begin errors++; $display("FAIL reset_saida actual=%h required=0000", saida); end
    checks++;
    if (slot !== 2'd0 || valido !== 1'b0 || erro !== 1'b0) begin
      errors++; $display("FAIL reset_flags actual slot=%0d valido=%b erro=%b required 0/0/0", slot, valido, erro);
    end
    idle(2);
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_basic_frame;
    int v0;
    send(1'b1, 4'hA);
    checks++;
    if (slot !== 2'd1) begin errors++; $display("FAIL basic_slot1 actual=%0d required=1", slot); end
    send(1'b0, 4'hB);
    send(1'b0, 4'hC);
    checks++;
    if (slot !== 2'd3 || saida !== 16'h0000) begin
      errors++; $display("FAIL basic_partial actual slot=%0d saida=%h required 3/0000", slot, saida);
    end
    v0 = valido_cnt;
    send(1'b0, 4'hD);
    checks++;
    if (valido !== 1'b1 || saida !== 16'hDCBA || slot !== 2'd0) begin
      errors++; $display("FAIL basic_done actual valido=%b saida=%h slot=%0d required 1/dcba/0", valido, saida, slot);
    end
    idle(2);
    checks++;
    if (valido !== 1'b0 || valido_cnt - v0 !== 1) begin
      errors++; $display("FAIL basic_pulse_width actual valido=%b cycles=%0d required 0/1", valido, valido_cnt - v0);
    end
  endtask

  task automatic test_gaps;
    int v0, e0;
    v0 = valido_cnt; e0 = erro_cnt;
    send(1'b1, 4'hA); idle(3);
    send(1'b0, 4'hB);
    @(negedge clk); sync = 1'b1;
    @(negedge clk); sync = 1'b0;
    idle(1);
    checks++;
    if (slot !== 2'd2) begin errors++; $display("FAIL gaps_sync_ignored actual slot=%0d required=2", slot); end
    send(1'b0, 4'hC); idle(3);
    send(1'b0, 4'hD); idle(3);
    checks++;
    if (saida !== 16'hDCBA || valido_cnt - v0 !== 1 || erro_cnt - e0 !== 0) begin
      errors++; $display("FAIL gaps_frame actual saida=%h valido_cycles=%0d erro_cycles=%0d required dcba/1/0",
                         saida, valido_cnt - v0, erro_cnt - e0);
    end
  endtask

  task automatic test_idle_discard;
    int v0, e0;
    v0 = valido_cnt; e0 = erro_cnt;
    send(1'b0, 4'h7);
    send(1'b0, 4'h8);
    idle(1);
    checks++;
    if (saida !== 16'hDCBA || slot !== 2'd0 || valido_cnt != v0 || erro_cnt != e0) begin
      errors++; $display("FAIL discard actual saida=%h slot=%0d pulses=%0d/%0d required dcba/0/0/0",
                         saida, slot, valido_cnt - v0, erro_cnt - e0);
    end
    send(1'b1, 4'h1); send(1'b0, 4'h2); send(1'b0, 4'h3); send(1'b0, 4'h4);
    checks++;
    if (saida !== 16'h4321) begin errors++; $display("FAIL discard_frame actual=%h required=4321", saida); end
  endtask

  task automatic test_resync;
    int e0, v0;
    idle(1);
    e0 = erro_cnt; v0 = valido_cnt;
    send(1'b1, 4'h1);
    send(1'b0, 4'h2);
    send(1'b1, 4'h9);
    checks++;
    if (erro !== 1'b1 || valido !== 1'b0 || slot !== 2'd1 || saida !== 16'h4321) begin
      errors++; $display("FAIL resync_pulse actual erro=%b valido=%b slot=%0d saida=%h required 1/0/1/4321",
                         erro, valido, slot, saida);
    end
    send(1'b0, 4'h8);
    send(1'b0, 4'h7);
    checks++;
    if (erro !== 1'b0 || saida !== 16'h4321) begin
      errors++; $display("FAIL resync_hold actual erro=%b saida=%h required 0/4321", erro, saida);
    end
    send(1'b0, 4'h6);
    checks++;
    if (saida !== 16'h6789 || valido !== 1'b1) begin
      errors++; $display("FAIL resync_frame actual saida=%h valido=%b required 6789/1", saida, valido);
    end
    idle(1);
    checks++;
    if (erro_cnt - e0 !== 1 || valido_cnt - v0 !== 1) begin
      errors++; $display("FAIL resync_counts actual erro=%0d valido=%0d required 1/1", erro_cnt - e0, valido_cnt - v0);
    end
  endtask

  task automatic test_async_reset;
    send(1'b1, 4'hA); send(1'b0, 4'hB); send(1'b0, 4'hC); send(1'b0, 4'hD);
    send(1'b1, 4'hA); send(1'b0, 4'hB);
    checks++;
    if (saida !== 16'hDCBA || slot !== 2'd2) begin
      errors++; $display("FAIL areset_pre actual saida=%h slot=%0d required dcba/2", saida, slot);
    end
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    checks++;
    if (saida !== 16'h0000 || slot !== 2'd0) begin
      errors++; $display("FAIL areset_immediate actual saida=%h slot=%0d required 0000/0", saida, slot);
    end
    @(negedge clk); reset = 1'b0;
    send(1'b0, 4'h5);
    send(1'b0, 4'h6);
    checks++;
    if (slot !== 2'd0 || saida !== 16'h0000) begin
      errors++; $display("FAIL areset_restart actual slot=%0d saida=%h required 0/0000", slot, saida);
    end
    send(1'b1, 4'h1); send(1'b0, 4'h2); send(1'b0, 4'h3); send(1'b0, 4'h4);
    checks++;
    if (saida !== 16'h4321 || valido !== 1'b1) begin
      errors++; $display("FAIL areset_frame actual saida=%h valido=%b required 4321/1", saida, valido);
    end
  endtask

  task automatic test_back_to_back;
    int v0, e0;
    idle(1);
    v0 = valido_cnt; e0 = erro_cnt;
    send(1'b1, 4'h5); send(1'b0, 4'h6); send(1'b0, 4'h7); send(1'b0, 4'h8);
    checks++;
    if (saida !== 16'h8765 || valido !== 1'b1) begin
      errors++; $display("FAIL b2b_first actual saida=%h valido=%b required 8765/1", saida, valido);
    end
    send(1'b1, 4'h1);
    checks++;
    if (valido !== 1'b0 || erro !== 1'b0 || slot !== 2'd1) begin
      errors++; $display("FAIL b2b_restart actual valido=%b erro=%b slot=%0d required 0/0/1", valido, erro, slot);
    end
    send(1'b0, 4'h2); send(1'b0, 4'h3); send(1'b0, 4'h4);
    checks++;
    if (saida !== 16'h4321 || valido !== 1'b1) begin
      errors++; $display("FAIL b2b_second actual saida=%h valido=%b required 4321/1", saida, valido);
    end
    idle(2);
    checks++;
    if (valido_cnt - v0 !== 2 || erro_cnt - e0 !== 0) begin
      errors++; $display("FAIL b2b_counts actual valido=%0d erro=%0d required 2/0", valido_cnt - v0, erro_cnt - e0);
    end
  endtask

  task automatic test_exclusive_pulses;
    checks++;
    if (both_cnt !== 0) begin
      errors++; $display("FAIL pulses_exclusive actual=%0d cycles with both high required=0", both_cnt);
    end
  endtask

  initial begin
    errors = 0; checks = 0;
    valido_cnt = 0; erro_cnt = 0; both_cnt = 0;
    test_reset;
    test_basic_frame;
    test_gaps;
    test_idle_discard;
    test_resync;
    test_async_reset;
    test_back_to_back;
    test_exclusive_pulses;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux.md
DEMUX -- requirements
Module: demux

Interface
REQ-001 Parameter LARGURA, default 4, SHALL set the width of one time-multiplexed slot (digit).
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL change on its rising edge.
REQ-003 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 en  input  1  SHALL be the slot-sample enable, a 1-cycle pulse from timer1seg's clk_out; no sampling while low.
REQ-005 sync  input  1  SHALL mark the first slot (slot 0) of a frame; it is meaningful only when en=1.
REQ-006 entrada  input  LARGURA  SHALL be the time-multiplexed slot data, sampled when en=1.
REQ-007 saida  output  4*LARGURA  SHALL hold the last complete frame, with slot 0 in the LSBs and slot 3 in the MSBs.
REQ-008 valido  output  1  SHALL pulse high for 1 cycle when saida updates.
REQ-009 erro  output  1  SHALL pulse high for 1 cycle on a frame-alignment error.
REQ-010 slot  output  2  SHALL show the index of the next expected slot (0..3).

Function
REQ-011 Block SHALL be the receive end of a 4-slot time-multiplexed link: it SHALL demultiplex serial slots back into a parallel 4-digit word.
REQ-012 FSM states SHALL be OCIOSO (waiting for sync) and RECEBE (collecting slots 1..3); the reset state SHALL be OCIOSO.
REQ-013 OCIOSO, en=1, sync=1: store entrada in buffer slot 0, set slot=1, go to RECEBE.
REQ-014 OCIOSO, en=1, sync=0: discard entrada; slot stays 0; no pulses.
REQ-015 RECEBE, en=1, sync=0: store entrada in buffer[slot] and increment slot.
REQ-016 When slot 3 is sampled, on that same edge: saida <= {entrada, buf2, buf1, buf0}, valido=1 for the following cycle, slot=0, state=OCIOSO.
REQ-017 RECEBE, en=1, sync=1 (premature sync): erro=1 for 1 cycle, discard the partial frame, store entrada as new slot 0, slot=1, stay in RECEBE.
REQ-018 en=0 in any state: hold all state; valido and erro SHALL be 0.
REQ-019 sync with en=0 SHALL be ignored.
REQ-020 saida SHALL change only on frame completion and reset; a partial or aborted frame SHALL never be visible on saida.
REQ-021 valido and erro SHALL never be high in the same cycle, and neither SHALL stay high longer than 1 cycle.
REQ-022 Back-to-back frames (sync on the en pulse right after slot 3) SHALL be accepted with no lost slot.
REQ-023 Latency from the en pulse that samples slot 3 to valido/saida SHALL be exactly 1 clock edge (registered outputs).
REQ-024 slot arithmetic SHALL be 2-bit and SHALL never pass 3; wrap to 0 happens only via REQ-016.

Reset
REQ-025 reset=1 SHALL immediately, without waiting for clk, force: state=OCIOSO, slot=0, buffer=0, saida=0, valido=0, erro=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame; after release, reception SHALL restart only on the next en&sync.
REQ-027 The first en pulse after reset release SHALL be handled normally per REQ-013/014.

Verification
REQ-028 LARGURA=4; en pulses carrying (sync=1,A),(0,B),(0,C),(0,D) -> saida=16'hDCBA, valido high for exactly 1 cycle, slot back to 0.
REQ-029 Same frame with 3 idle cycles between en pulses, plus sync=1 while en=0 -> saida=16'hDCBA; no erro.
REQ-030 In OCIOSO, en pulses with sync=0 and data 7,8 -> saida unchanged, no pulses; then a frame 1,2,3,4 -> 16'h4321.
REQ-031 Frame 1,2 then sync=1 with data 9, then 8,7,6 -> erro pulse at the resync; saida=16'h6789; old saida held until then.
REQ-032 After saida=16'hDCBA, assert reset asynchronously between clk edges at slot 2 -> saida=0 and slot=0 at once; the next full frame is received correctly.
REQ-033 Two consecutive frames with no gap (5,6,7,8 then 1,2,3,4) -> valido pulses twice, saida=16'h8765 then 16'h4321.
